jtag_tap_oversampled: RTL and testbench
=======================================

// Module: jtag_tap_oversampled
// PURPOSE
//  IEEE 1149.1 TAP controller that sits directly downstream of the JTAG pins (tck/tms/tdi/trst_n) inside the SoC.
//  It oversamples the JTAG pins on the system clock and synchronizes them into that domain.
//  It runs the 16-state TAP FSM and implements the IR, IDCODE and BYPASS registers.
//  All other instructions go to an external data register (the debug module's DMI) through strobes and a TDO return path.
// PARAMETERS
//  IR_LEN       5             instruction register width, bits
//  IDCODE_VAL   32'h1000_0001 value captured in IDCODE DR; bit 0 must be 1
//  SYNC_STAGES  2             synchronizer flops per JTAG input, >=2
// PORTS
//  clk_i         in   1       system clock, sole clock
//  rst_i         in   1       asynchronous, active-high reset
//  tck_i         in   1       JTAG clock pin, asynchronous to clk_i
//  tms_i         in   1       JTAG mode select
//  tdi_i         in   1       JTAG data in
//  trst_ni       in   1       JTAG test reset, active-low, async
//  tdo_o         out  1       JTAG data out
//  tap_state_o   out  4       current TAP state (encoding below)
//  ir_o          out  IR_LEN  current (updated) instruction
//  ext_sel_o     out  1       1 when ir_o is neither IDCODE nor BYPASS
//  ext_capture_o out  1       1-clk pulse: entering Capture-DR with ext_sel_o=1
//  ext_shift_o   out  1       1-clk pulse per TCK rise while in Shift-DR with ext_sel_o=1
//  ext_update_o  out  1       1-clk pulse: entering Update-DR with ext_sel_o=1
//  ext_tdi_o     out  1       synchronized tdi, valid with ext_shift_o
//  ext_tdo_i     in   1       LSB of the external DR, sampled at TCK fall
// BEHAVIOUR
//  - Reset (rst_i=1): tdo_o=0, tap_state_o=TLR, ir_o=IDCODE(5'h01), ext_* outputs=0, sync flops=0, trst sync=0.
//  - Sync: tck, tms, tdi and trst_n each pass through SYNC_STAGES flops.
//    - tck_rise: sync tck=1 and previous=0. tck_fall: sync tck=0 and previous=1.
//    - Latency from a pin edge to the FSM update = SYNC_STAGES+1 clk_i cycles.
//  - Timing requirement: TCK high and low phases each >= SYNC_STAGES+2 clk_i periods. Shorter phases are unsupported.
//  - State encoding:
//    TLR=0 RTI=1 SELDR=2 CAPDR=3 SHDR=4 EX1DR=5 PDR=6 EX2DR=7 UPDDR=8
//    SELIR=9 CAPIR=10 SHIR=11 EX1IR=12 PIR=13 EX2IR=14 UPDIR=15.
//  - Transitions follow the standard 1149.1 graph. They occur only on tck_rise, using the synchronized tms sampled in that cycle.
//  - Actions on tck_rise (based on the current state, before the transition):
//    - CAPIR: IR shift reg <= {{IR_LEN-1{0}},1}.
//    - SHIR: IR shift reg <= {tdi, sr[IR_LEN-1:1]}.
//    - CAPDR: IDCODE sr <= IDCODE_VAL; bypass bit <= 0.
//    - SHDR: the selected DR shifts right, tdi enters at MSB. The bypass bit takes tdi.
//  - Entering UPDIR: ir_o <= IR shift reg.
//  - Entering TLR (by TMS or sync trst=0): ir_o <= 5'h01.
//  - Decode: 5'h01 = IDCODE; all-ones = BYPASS; any other value = external (ext_sel_o=1).
//  - ext strobes are asserted in the same clk as the tck_rise that causes the corresponding state entry/shift.
//  - tdo_o changes only on tck_fall:
//    - In SHIR: IR sr[0].
//    - In SHDR: IDCODE sr[0], bypass bit, or ext_tdo_i, per ir_o.
//    - Otherwise tdo_o holds its last value.
//  - Synchronized trst_n=0: forces TLR and ir_o=IDCODE every cycle until it is released. This takes priority over tck_rise.
//  - tck_rise and tck_fall are mutually exclusive by construction.
//  - rst_i mid-shift aborts immediately. No update strobe is issued.
// TESTING
//  - rst_i pulse -> tap_state_o=0, ir_o=5'h01, tdo_o=0, ext_* all 0.
//  - From RTI, TMS=1 for 5 TCKs -> tap_state_o=TLR after 5th rise + SYNC_STAGES+1 clks.
//  - TLR->SHDR, shift 32 TCKs with tdi=0 -> tdo bits LSB-first = 32'h1000_0001.
//  - Shift IR with tdi=5'b11111 -> capture bits out are 1,0,0,0,0; ir_o=5'h1F at UPDIR.
//    - Then Shift-DR tdi=1,0,1,1 -> tdo=0,1,0,1 (one-TCK delay).
//  - Load IR=5'h11, pass through CAPDR, 8 shifts, UPDDR:
//    - ext_capture_o 1 pulse, ext_shift_o 8 pulses, ext_update_o 1 pulse.
//    - tdo_o mirrors ext_tdo_i at each fall.
//  - trst_ni=0 mid Shift-DR -> TLR within SYNC_STAGES+1 clks, ir_o=5'h01, no ext_update_o pulse.

Source files
------------

// File: rtl/jtag_tap_oversampled.sv
// rtl/jtag_tap_oversampled.sv - IEEE 1149.1 TAP controller oversampling the JTAG pins on the system clock
module jtag_tap_oversampled #(
    parameter int          IR_LEN      = 5,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tck_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    input  logic              trst_ni,
    output logic              tdo_o,
    output logic [3:0]        tap_state_o,
    output logic [IR_LEN-1:0] ir_o,
    output logic              ext_sel_o,
    output logic              ext_capture_o,
    output logic              ext_shift_o,
    output logic              ext_update_o,
    output logic              ext_tdi_o,
    input  logic              ext_tdo_i
);

    typedef enum logic [3:0] {
        TLR   = 4'd0,
        RTI   = 4'd1,
        SELDR = 4'd2,
        CAPDR = 4'd3,
        SHDR  = 4'd4,
        EX1DR = 4'd5,
        PDR   = 4'd6,
        EX2DR = 4'd7,
        UPDDR = 4'd8,
        SELIR = 4'd9,
        CAPIR = 4'd10,
        SHIR  = 4'd11,
        EX1IR = 4'd12,
        PIR   = 4'd13,
        EX2IR = 4'd14,
        UPDIR = 4'd15
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_IDCODE = {{(IR_LEN-1){1'b0}}, 1'b1};
    localparam logic [IR_LEN-1:0] IR_BYPASS = {IR_LEN{1'b1}};

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic [SYNC_STAGES-1:0] trst_sync;
    logic                   tck_prev;

    logic tck_s;
    logic tms_s;
    logic tdi_s;
    logic trst_active;
    logic tck_rise;
    logic tck_fall;

    tap_state_t        state;
    tap_state_t        state_next;
    logic [IR_LEN-1:0] ir_sr;
    logic [IR_LEN-1:0] ir_q;
    logic [31:0]       idcode_sr;
    logic              bypass_q;
    logic              tdo_q;
    logic              ir_is_idcode;
    logic              ir_is_bypass;
    logic              ext_sel;
    logic              dr_step;

    // Bring every JTAG pin into the clk_i domain and remember the previous synchronized tck
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tck_i};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms_i};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], tdi_i};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_ni};
            tck_prev  <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s       = tck_sync[SYNC_STAGES-1];
    assign tms_s       = tms_sync[SYNC_STAGES-1];
    assign tdi_s       = tdi_sync[SYNC_STAGES-1];
    assign trst_active = ~trst_sync[SYNC_STAGES-1];
    assign tck_rise    = tck_s & ~tck_prev;
    assign tck_fall    = ~tck_s & tck_prev;

    // TAP state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    // 1149.1 transition graph, advanced only on a synchronized tck rise; trst wins
    always_comb begin
        state_next = state;
        if (trst_active) begin
            state_next = TLR;
        end else if (tck_rise) begin
            case (state)
                TLR:     state_next = tms_s ? TLR   : RTI;
                RTI:     state_next = tms_s ? SELDR : RTI;
                SELDR:   state_next = tms_s ? SELIR : CAPDR;
                CAPDR:   state_next = tms_s ? EX1DR : SHDR;
                SHDR:    state_next = tms_s ? EX1DR : SHDR;
                EX1DR:   state_next = tms_s ? UPDDR : PDR;
                PDR:     state_next = tms_s ? EX2DR : PDR;
                EX2DR:   state_next = tms_s ? UPDDR : SHDR;
                UPDDR:   state_next = tms_s ? SELDR : RTI;
                SELIR:   state_next = tms_s ? TLR   : CAPIR;
                CAPIR:   state_next = tms_s ? EX1IR : SHIR;
                SHIR:    state_next = tms_s ? EX1IR : SHIR;
                EX1IR:   state_next = tms_s ? UPDIR : PIR;
                PIR:     state_next = tms_s ? EX2IR : PIR;
                EX2IR:   state_next = tms_s ? UPDIR : SHIR;
                UPDIR:   state_next = tms_s ? SELDR : RTI;
                default: state_next = TLR;
            endcase
        end
    end

    assign ir_is_idcode = (ir_q == IR_IDCODE);
    assign ir_is_bypass = (ir_q == IR_BYPASS);
    assign ext_sel      = ~ir_is_idcode & ~ir_is_bypass;

    // Instruction shift register and the updated instruction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_sr <= IR_IDCODE;
            ir_q  <= IR_IDCODE;
        end else if (trst_active) begin
            ir_q <= IR_IDCODE;
        end else if (tck_rise) begin
            if (state == CAPIR) begin
                ir_sr <= IR_IDCODE;
            end else if (state == SHIR) begin
                ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
            end
            if (state_next == UPDIR) begin
                ir_q <= ir_sr;
            end else if (state_next == TLR) begin
                ir_q <= IR_IDCODE;
            end
        end
    end

    // Internal data registers: IDCODE shifter and the single bypass bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idcode_sr <= '0;
            bypass_q  <= 1'b0;
        end else if (tck_rise && !trst_active) begin
            if (state == CAPDR) begin
                idcode_sr <= IDCODE_VAL;
                bypass_q  <= 1'b0;
            end else if (state == SHDR) begin
                if (ir_is_idcode) begin
                    idcode_sr <= {tdi_s, idcode_sr[31:1]};
                end
                bypass_q <= tdi_s;
            end
        end
    end

    // tdo launches on the falling tck edge so the host samples it stable on the next rise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_q <= 1'b0;
        end else if (tck_fall && !trst_active) begin
            if (state == SHIR) begin
                tdo_q <= ir_sr[0];
            end else if (state == SHDR) begin
                if (ir_is_idcode) begin
                    tdo_q <= idcode_sr[0];
                end else if (ir_is_bypass) begin
                    tdo_q <= bypass_q;
                end else begin
                    tdo_q <= ext_tdo_i;
                end
            end
        end
    end

    assign dr_step = tck_rise & ~trst_active & ext_sel;

    assign tdo_o         = tdo_q;
    assign tap_state_o   = state;
    assign ir_o          = ir_q;
    assign ext_sel_o     = ext_sel;
    assign ext_capture_o = dr_step & (state_next == CAPDR);
    assign ext_shift_o   = dr_step & (state == SHDR);
    assign ext_update_o  = dr_step & (state_next == UPDDR);
    assign ext_tdi_o     = tdi_s;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb/tb_jtag_tap_oversampled.sv - randomized model-checked bench for jtag_tap_oversampled
module tb_jtag_tap_oversampled;

    localparam int          SYNC = 2;
    localparam logic [31:0] IDC  = 32'h1000_0001;

    localparam logic [3:0] S_TLR   = 4'd0;
    localparam logic [3:0] S_CAPDR = 4'd3;
    localparam logic [3:0] S_SHDR  = 4'd4;
    localparam logic [3:0] S_UPDDR = 4'd8;
    localparam logic [3:0] S_CAPIR = 4'd10;
    localparam logic [3:0] S_SHIR  = 4'd11;
    localparam logic [3:0] S_UPDIR = 4'd15;

    // Successor of each state for tms=0 and tms=1, indexed by state code
    localparam logic [3:0] NXT0 [16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                                         4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
    localparam logic [3:0] NXT1 [16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                                         4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

    logic       clk = 1'b0;
    logic       rst, tck, tms, tdi, trst_n, ext_tdo;
    logic       tdo, ext_sel, ext_cap, ext_shift, ext_upd, ext_tdi;
    logic [3:0] tap_state;
    logic [4:0] ir;

    always #5 clk = ~clk;

    jtag_tap_oversampled #(.IR_LEN(5), .IDCODE_VAL(IDC), .SYNC_STAGES(SYNC)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tck_i         (tck),
        .tms_i         (tms),
        .tdi_i         (tdi),
        .trst_ni       (trst_n),
        .tdo_o         (tdo),
        .tap_state_o   (tap_state),
        .ir_o          (ir),
        .ext_sel_o     (ext_sel),
        .ext_capture_o (ext_cap),
        .ext_shift_o   (ext_shift),
        .ext_update_o  (ext_upd),
        .ext_tdi_o     (ext_tdi),
        .ext_tdo_i     (ext_tdo)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Model of the TAP as seen from the pins, advanced when the bench drives a tck edge
    logic [3:0]  m_state;
    logic [4:0]  m_ir, m_ir_sr;
    logic [31:0] m_id;
    logic        m_byp, m_tdo;

    // Values the DUT must show now, plus one pending snapshot that becomes visible later
    logic [3:0] e_state;
    logic [4:0] e_ir;
    logic       e_tdo;
    bit         p_valid = 1'b0;
    int         p_at;
    logic [3:0] p_state;
    logic [4:0] p_ir;
    logic       p_tdo;
    int         s_at = -1;
    logic       s_cap, s_shift, s_upd, s_tdi;

    int n_cap = 0, n_shift = 0, n_upd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit is_ext(input logic [4:0] v);
        return (v != 5'h01) && (v != 5'h1F);
    endfunction

    task automatic schedule(input int at);
        p_valid = 1'b1;
        p_at    = at;
        p_state = m_state;
        p_ir    = m_ir;
        p_tdo   = m_tdo;
    endtask

    task automatic model_reset();
        m_state = S_TLR; m_ir = 5'h01; m_ir_sr = 5'h01; m_id = '0; m_byp = 1'b0; m_tdo = 1'b0;
        e_state = S_TLR; e_ir = 5'h01; e_tdo = 1'b0;
        p_valid = 1'b0;
        s_at    = -1;
    endtask

    // Pin rise: strobes show two clocks later, the new state/ir one clock after that
    task automatic model_rise(input bit t_ms, input bit t_di);
        logic [3:0] ns;
        ns      = t_ms ? NXT1[m_state] : NXT0[m_state];
        s_at    = cyc + SYNC;
        s_cap   = is_ext(m_ir) && (ns == S_CAPDR);
        s_shift = is_ext(m_ir) && (m_state == S_SHDR);
        s_upd   = is_ext(m_ir) && (ns == S_UPDDR);
        s_tdi   = t_di;
        if (m_state == S_CAPIR) m_ir_sr = 5'h01;
        if (m_state == S_SHIR)  m_ir_sr = {t_di, m_ir_sr[4:1]};
        if (m_state == S_CAPDR) begin m_id = IDC; m_byp = 1'b0; end
        if (m_state == S_SHDR) begin
            if (m_ir == 5'h01) m_id = {t_di, m_id[31:1]};
            m_byp = t_di;
        end
        m_state = ns;
        if (ns == S_UPDIR) m_ir = m_ir_sr;
        if (ns == S_TLR)   m_ir = 5'h01;
        schedule(cyc + SYNC + 1);
    endtask

    task automatic model_fall(input bit edo);
        if (m_state == S_SHIR) m_tdo = m_ir_sr[0];
        else if (m_state == S_SHDR) m_tdo = (m_ir == 5'h01) ? m_id[0] : (m_ir == 5'h1F) ? m_byp : edo;
        schedule(cyc + SYNC + 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every output against the model on every cycle
    initial forever begin
        @(negedge clk);
        if (p_valid && cyc >= p_at) begin
            e_state = p_state;
            e_ir    = p_ir;
            e_tdo   = p_tdo;
            p_valid = 1'b0;
        end
        chk("tap_state", tap_state, e_state);
        chk("ir", ir, e_ir);
        chk("tdo", tdo, e_tdo);
        chk("ext_sel", ext_sel, is_ext(e_ir));
        chk("ext_capture", ext_cap, (cyc == s_at) ? s_cap : 1'b0);
        chk("ext_shift", ext_shift, (cyc == s_at) ? s_shift : 1'b0);
        chk("ext_update", ext_upd, (cyc == s_at) ? s_upd : 1'b0);
        if (cyc == s_at && s_shift) chk("ext_tdi", ext_tdi, s_tdi);
    end

    initial forever begin
        @(negedge clk);
        n_cap   += int'(ext_cap);
        n_shift += int'(ext_shift);
        n_upd   += int'(ext_upd);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tck_cycle(input bit t_ms, input bit t_di, output bit tdo_seen, output bit edo);
        edo     = 1'($urandom_range(0, 1));
        tms     = t_ms;
        tdi     = t_di;
        ext_tdo = edo;
        step($urandom_range(1, 3));
        tck = 1'b1;
        model_rise(t_ms, t_di);
        step($urandom_range(SYNC + 2, SYNC + 4));
        tck = 1'b0;
        model_fall(edo);
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
        tdo_seen = tdo;
        step(1);
    endtask

    task automatic tck_tms(input bit t_ms);
        bit t, e;
        tck_cycle(t_ms, 1'b0, t, e);
    endtask

    // From RTI: scan n bits through DR, return tdo seen after each fall and the ext_tdo driven then
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout, output logic [31:0] eout);
        bit t, e;
        dout = '0;
        eout = '0;
        tck_tms(1'b1);
        tck_tms(1'b0);
        tck_cycle(1'b0, 1'b0, t, e);
        dout[0] = t;
        eout[0] = e;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], t, e);
            if (i < n - 1) begin
                dout[i+1] = t;
                eout[i+1] = e;
            end
        end
        tck_tms(1'b1);
        tck_tms(1'b0);
    endtask

    task automatic shift_ir(input logic [4:0] val, output logic [4:0] cap);
        bit t, e;
        cap = '0;
        tck_tms(1'b1);
        tck_tms(1'b1);
        tck_tms(1'b0);
        tck_cycle(1'b0, 1'b0, t, e);
        cap[0] = t;
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, val[i], t, e);
            if (i < 4) cap[i+1] = t;
        end
        tck_tms(1'b1);
        tck_tms(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, e;
        logic [4:0]  c;
        bit          t, ed;
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1; ext_tdo = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_state", tap_state, 0);
        chk("rst_ir", ir, 5'h01);
        chk("rst_tdo", tdo, 0);
        chk("rst_ext", {ext_sel, ext_cap, ext_shift, ext_upd, ext_tdi}, 0);
        step(1);
        rst = 1'b0;
        step(4);

        // RTI then five TMS=1 clocks back to Test-Logic-Reset
        tck_tms(1'b0);
        for (int i = 0; i < 5; i++) tck_tms(1'b1);
        chk("tlr_after_5", tap_state, 0);

        // IDCODE read-out, LSB first
        tck_tms(1'b0);
        shift_dr(32, 32'h0, d, e);
        chk("idcode", d, IDC);

        // IR capture pattern and BYPASS selection
        shift_ir(5'h1F, c);
        chk("ir_capture", c, 5'b00001);
        chk("ir_bypass", ir, 5'h1F);
        shift_dr(4, 32'b1101, d, e);
        chk("bypass_tdo", d[3:0], 4'b1010);

        // External DR: strobe counts and tdo mirroring
        shift_ir(5'h11, c);
        chk("ir_ext", ir, 5'h11);
        chk("ext_sel_on", ext_sel, 1);
        n_cap = 0; n_shift = 0; n_upd = 0;
        shift_dr(8, 32'($urandom_range(0, 255)), d, e);
        chk("ext_cap_cnt", n_cap, 1);
        chk("ext_shift_cnt", n_shift, 8);
        chk("ext_upd_cnt", n_upd, 1);
        chk("ext_tdo_mirror", d[7:0], e[7:0]);

        // trst_n asserted in the middle of Shift-DR
        n_upd = 0;
        tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
        tck_cycle(1'b0, 1'b1, t, ed);
        tck_cycle(1'b0, 1'b0, t, ed);
        trst_n = 1'b0;
        m_state = S_TLR;
        m_ir    = 5'h01;
        schedule(cyc + SYNC + 1);
        step(SYNC + 1);
        @(negedge clk);
        chk("trst_state", tap_state, 0);
        chk("trst_ir", ir, 5'h01);
        step(4);
        trst_n = 1'b1;
        step(4);
        chk("trst_no_upd", n_upd, 0);

        // rst_i asserted in the middle of Shift-DR
        tck_tms(1'b0);
        shift_ir(5'h05, c);
        n_upd = 0;
        tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
        tck_cycle(1'b0, 1'b1, t, ed);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_state", tap_state, 0);
        chk("midrst_ir", ir, 5'h01);
        chk("midrst_tdo", tdo, 0);
        step(3);
        rst = 1'b0;
        step(4);
        chk("midrst_no_upd", n_upd, 0);

        // Random walk over the whole graph
        for (int i = 0; i < 400; i++) begin
            tck_cycle($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)), t, ed);
        end
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
